// File: rtl/fib_pkg.sv
// Shared widths and FSMD state encoding for the Fibonacci generator/decoder pair.
package fib_pkg;

  localparam int unsigned FIB_W       = 20;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned FIB_MAX_IDX = 30;

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_operate = 2'd1,
    e_done    = 2'd2
  } t_fib_state;

endpackage

// File: rtl/fib_index.sv
// Inverse Fibonacci engine: largest n with fib(n) <= value, plus exactness and remainder.
module fib_index
  import fib_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [FIB_W-1:0] i_value,
  output logic             o_ready,
  output logic             o_done_tick,
  output logic [IDX_W-1:0] o_index,
  output logic             o_exact,
  output logic [FIB_W-1:0] o_fib_floor,
  output logic [FIB_W-1:0] o_remainder
);

  t_fib_state       state, state_n;
  logic [FIB_W-1:0] r_v, v_n;
  logic [FIB_W-1:0] r_a, a_n;
  logic [FIB_W:0]   r_b, b_n;
  logic [IDX_W-1:0] r_k, k_n;
  logic [IDX_W-1:0] r_index, index_n;
  logic             r_exact, exact_n;
  logic [FIB_W-1:0] r_floor, floor_n;
  logic [FIB_W-1:0] r_rem, rem_n;

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= e_idle;
      r_v     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_index <= '0;
      r_exact <= 1'b0;
      r_floor <= '0;
      r_rem   <= '0;
    end else begin
      state   <= state_n;
      r_v     <= v_n;
      r_a     <= a_n;
      r_b     <= b_n;
      r_k     <= k_n;
      r_index <= index_n;
      r_exact <= exact_n;
      r_floor <= floor_n;
      r_rem   <= rem_n;
    end
  end

  // Next-state and datapath: walk fib(k), fib(k+1) upward until fib(k+1) exceeds the value.
  always_comb begin
    state_n = state;
    v_n     = r_v;
    a_n     = r_a;
    b_n     = r_b;
    k_n     = r_k;
    index_n = r_index;
    exact_n = r_exact;
    floor_n = r_floor;
    rem_n   = r_rem;
    case (state)
      e_idle: begin
        if (i_start) begin
          v_n     = i_value;
          a_n     = '0;
          b_n     = (FIB_W+1)'(1);
          k_n     = '0;
          state_n = e_operate;
        end
      end
      e_operate: begin
        if (r_b <= {1'b0, r_v}) begin
          a_n = r_b[FIB_W-1:0];
          b_n = (FIB_W+1)'(r_a) + r_b;
          k_n = r_k + IDX_W'(1);
        end else begin
          index_n = r_k;
          floor_n = r_a;
          exact_n = (r_a == r_v);
          rem_n   = r_v - r_a;
          state_n = e_done;
        end
      end
      e_done: begin
        state_n = e_idle;
      end
      default: begin
        state_n = e_idle;
      end
    endcase
  end

  assign o_ready     = (state == e_idle);
  assign o_done_tick = (state == e_done);
  assign o_index     = r_index;
  assign o_exact     = r_exact;
  assign o_fib_floor = r_floor;
  assign o_remainder = r_rem;

endmodule

// File: tb/tb_fib_index.sv
// Scoreboard bench for fib_index: driver queues model results, monitor checks on done_tick.
module tb_fib_index;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [19:0] i_value = '0;
  logic        o_ready;
  logic        o_done_tick;
  logic [4:0]  o_index;
  logic        o_exact;
  logic [19:0] o_fib_floor;
  logic [19:0] o_remainder;

  fib_index dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_value     (i_value),
    .o_ready     (o_ready),
    .o_done_tick (o_done_tick),
    .o_index     (o_index),
    .o_exact     (o_exact),
    .o_fib_floor (o_fib_floor),
    .o_remainder (o_remainder)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int unsigned idx;
    int unsigned exact;
    int unsigned floor_v;
    int unsigned rem;
    int unsigned e0;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  bit          prev_done = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan the Fibonacci sequence and keep the largest n with fib(n) <= v.
  function automatic exp_t model(input int unsigned v);
    int unsigned f[0:31];
    exp_t r;
    f[0] = 0;
    f[1] = 1;
    for (int i = 2; i < 32; i++) f[i] = f[i-1] + f[i-2];
    r.idx = 0;
    for (int n = 0; n <= 30; n++) if (f[n] <= v) r.idx = n;
    r.floor_v = f[r.idx];
    r.exact   = (f[r.idx] == v) ? 1 : 0;
    r.rem     = v - f[r.idx];
    r.e0      = 0;
    return r;
  endfunction

  // Monitor: each done_tick must match the oldest outstanding request.
  always @(negedge i_clk) begin
    if (prev_done) begin
      chk("ready_after_done", 32'(o_ready), 1);
      chk("done_one_cycle", 32'(o_done_tick), 0);
    end
    prev_done = o_done_tick;
    if (o_done_tick) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_tick with no request outstanding (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("index", 32'(o_index), e.idx);
        chk("exact", 32'(o_exact), e.exact);
        chk("fib_floor", 32'(o_fib_floor), e.floor_v);
        chk("remainder", 32'(o_remainder), e.rem);
        chk("latency", cyc - e.e0, e.idx + 1);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: ready=0 expected 1 after 100 cycles");
    end
  endtask

  // Issue one request from idle and queue its expected result.
  task automatic start(input int unsigned v);
    exp_t e;
    wait_ready();
    i_start = 1'b1;
    i_value = 20'(v);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    e = model(v);
    e.e0 = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    wait_ready();
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 1);
    chk({tag, "_done"}, 32'(o_done_tick), 0);
    chk({tag, "_index"}, 32'(o_index), 0);
    chk({tag, "_exact"}, 32'(o_exact), 0);
    chk({tag, "_floor"}, 32'(o_fib_floor), 0);
    chk({tag, "_rem"}, 32'(o_remainder), 0);
  endtask

  initial begin
    int unsigned f[0:31];
    int unsigned v;
    f[0] = 0;
    f[1] = 1;
    for (int i = 2; i < 32; i++) f[i] = f[i-1] + f[i-2];

    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check_idle_zero("reset");

    // Directed corner values.
    start(0);       drain();
    start(1);       drain();
    start(4);       drain();
    start(21);      drain();
    start(832040);  drain();
    start(1048575); drain();

    // Values straddling Fibonacci numbers.
    for (int n = 2; n <= 30; n += 4) begin
      start(f[n] - 1); drain();
      start(f[n]);     drain();
      start(f[n] + 1); drain();
    end

    // Random values.
    for (int i = 0; i < 30; i++) begin
      v = $urandom_range(0, 1048575);
      start(v);
      drain();
    end

    // Starts during operate and done are ignored.
    start(832040);
    repeat (5) @(negedge i_clk);
    i_start = 1'b1;
    i_value = 20'd7;
    @(negedge i_clk);
    i_start = 1'b0;
    begin
      int n = 0;
      while (!o_done_tick && n < 100) begin
        @(negedge i_clk);
        n++;
      end
    end
    i_start = 1'b1;
    i_value = 20'd3;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    repeat (40) @(negedge i_clk);
    chk("ignored_pending", sb.size(), 0);
    chk("ignored_index_hold", 32'(o_index), 30);
    chk("ignored_exact_hold", 32'(o_exact), 1);

    // Reset midway through a long run aborts it.
    start(1048575);
    repeat (14) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    sb.delete();
    @(negedge i_clk);
    check_idle_zero("midreset");
    repeat (40) @(negedge i_clk);
    chk("midreset_ready_hold", 32'(o_ready), 1);

    // Reset wins over a simultaneous start.
    @(negedge i_clk);
    i_rst = 1'b1;
    i_start = 1'b1;
    i_value = 20'd100;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_start = 1'b0;
    @(negedge i_clk);
    chk("rst_prio_ready", 32'(o_ready), 1);
    repeat (20) @(negedge i_clk);
    chk("rst_prio_index", 32'(o_index), 0);

    start(21);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
